logic_unit_pipe: RTL and testbench

//  Parametrised, registered successor to the 8-bit combinational logic unit.

---
 rtl/logic_unit_pkg.sv | 16 +
 rtl/logic_unit_pipe_fn.sv | 29 ++
 rtl/logic_unit_pipe.sv | 118 +++++++++++
 tb/tb_logic_unit_pipe.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared op codes and mode constants for the pipelined logic unit.
package logic_unit_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NOT  = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_XNOR = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  localparam logic MODE_ELEM = 1'b0;
  localparam logic MODE_RED  = 1'b1;

endpackage

// File: rtl/logic_unit_pipe_fn.sv
// Combinational bitwise function f(x, y, op) shared by both operating modes.
module logic_fn
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic [2:0]       i_op,
  output logic [WIDTH-1:0] o_f
);

  // Decode the op select into the selected bitwise result.
  always_comb begin
    o_f = '0;
    unique case (i_op)
      OP_AND:  o_f = i_x & i_y;
      OP_OR:   o_f = i_x | i_y;
      OP_XOR:  o_f = i_x ^ i_y;
      OP_NOT:  o_f = ~i_x;
      OP_NAND: o_f = ~(i_x & i_y);
      OP_NOR:  o_f = ~(i_x | i_y);
      OP_XNOR: o_f = ~(i_x ^ i_y);
      OP_PASS: o_f = i_y;
      default: o_f = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered logic unit with valid/ready stream ports, elementwise and packet-reduce modes.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_mode,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_d,
  output logic             out_zero,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_beats
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic             r_valid;
  logic [WIDTH-1:0] r_d;
  logic             r_zero;
  logic             r_parity;
  logic [CNT_W-1:0] r_beats;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_op;
  logic             r_pkt;

  logic             w_accept;
  logic             w_elem;
  logic             w_red_first;
  logic [WIDTH-1:0] w_fn_x;
  logic [WIDTH-1:0] w_fn_y;
  logic [2:0]       w_fn_op;
  logic [WIDTH-1:0] w_fn;
  logic [WIDTH-1:0] w_acc_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_load;
  logic [WIDTH-1:0] w_load_d;
  logic [CNT_W-1:0] w_load_beats;

  // Handshake and datapath steering; continuation beats fold into the accumulator.
  always_comb begin
    in_ready     = !r_valid || out_ready;
    w_accept     = in_valid && in_ready;
    w_elem       = !r_pkt && (in_mode == MODE_ELEM);
    w_red_first  = !r_pkt && (in_mode == MODE_RED);
    w_fn_x       = r_pkt ? r_acc : in_a;
    w_fn_y       = r_pkt ? in_a  : in_b;
    w_fn_op      = r_pkt ? r_op  : in_op;
    w_acc_next   = w_red_first ? in_a : w_fn;
    w_cnt_next   = w_red_first ? CntOne : ((r_cnt == CntMax) ? r_cnt : r_cnt + CntOne);
    w_load       = w_accept && (w_elem || in_last);
    w_load_d     = w_elem ? w_fn : w_acc_next;
    w_load_beats = w_elem ? CntOne : w_cnt_next;
  end

  logic_fn #(
    .WIDTH (WIDTH)
  ) u_fn (
    .i_x  (w_fn_x),
    .i_y  (w_fn_y),
    .i_op (w_fn_op),
    .o_f  (w_fn)
  );

  // Output register: a new result wins over a same-cycle sink transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_d      <= '0;
      r_zero   <= 1'b0;
      r_parity <= 1'b0;
      r_beats  <= '0;
    end else if (w_load) begin
      r_valid  <= 1'b1;
      r_d      <= w_load_d;
      r_zero   <= (w_load_d == '0);
      r_parity <= ^w_load_d;
      r_beats  <= w_load_beats;
    end else if (out_ready) begin
      r_valid  <= 1'b0;
    end
  end

  // Reduce-packet state: accumulator, saturating beat count, latched op, in-packet flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_op  <= OP_AND;
      r_pkt <= 1'b0;
    end else if (w_accept && !w_elem) begin
      r_acc <= w_acc_next;
      r_cnt <= w_cnt_next;
      r_pkt <= !in_last;
      if (w_red_first) begin
        r_op <= in_op;
      end
    end
  end

  assign out_valid  = r_valid;
  assign out_d      = r_d;
  assign out_zero   = r_zero;
  assign out_parity = r_parity;
  assign out_beats  = r_beats;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench: two DUTs (CNT_W=8 and CNT_W=2) share stimulus and are compared
// each cycle against a transaction-level model, plus hand-computed directed checks.
module tb_logic_unit_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic [2:0] in_op = '0;
  logic       in_mode = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b1;

  logic       in_ready, out_valid, out_zero, out_parity;
  logic [7:0] out_d, out_beats;
  logic       in_ready2, out_valid2, out_zero2, out_parity2;
  logic [7:0] out_d2;
  logic [1:0] out_beats2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(8), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
    .in_b(in_b), .in_op(in_op), .in_mode(in_mode), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_d(out_d), .out_zero(out_zero),
    .out_parity(out_parity), .out_beats(out_beats)
  );

  logic_unit_pipe #(.WIDTH(8), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_a(in_a),
    .in_b(in_b), .in_op(in_op), .in_mode(in_mode), .in_last(in_last),
    .out_valid(out_valid2), .out_ready(out_ready), .out_d(out_d2), .out_zero(out_zero2),
    .out_parity(out_parity2), .out_beats(out_beats2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] f(input logic [7:0] x, input logic [7:0] y,
                                   input logic [2:0] op);
    case (op)
      3'd0:    return x & y;
      3'd1:    return x | y;
      3'd2:    return x ^ y;
      3'd3:    return ~x;
      3'd4:    return ~(x & y);
      3'd5:    return ~(x | y);
      3'd6:    return ~(x ^ y);
      default: return y;
    endcase
  endfunction

  // Reference model: expected output register contents and packet progress.
  logic       m_valid = 1'b0;
  logic [7:0] m_d = '0;
  logic       m_zero = 1'b0;
  logic       m_par = 1'b0;
  int         m_beats = 0;
  logic       m_pkt = 1'b0;
  logic [2:0] m_op = '0;
  logic [7:0] m_acc = '0;
  int         m_cnt = 0;

  always @(posedge clk or posedge rst) begin
    logic       take;
    logic       load;
    logic [7:0] res;
    int         n;
    if (rst) begin
      m_valid <= 1'b0; m_d <= '0; m_zero <= 1'b0; m_par <= 1'b0; m_beats <= 0;
      m_pkt <= 1'b0; m_acc <= '0; m_cnt <= 0;
    end else begin
      take = in_valid && (!m_valid || out_ready);
      load = 1'b0;
      res  = '0;
      n    = 0;
      if (take) begin
        if (!m_pkt && !in_mode) begin
          load = 1'b1; res = f(in_a, in_b, in_op); n = 1;
        end else begin
          if (!m_pkt) begin
            res = in_a; n = 1; m_op <= in_op;
          end else begin
            res = f(m_acc, in_a, m_op); n = m_cnt + 1;
          end
          m_acc <= res;
          m_cnt <= n;
          m_pkt <= !in_last;
          load  = in_last;
        end
      end
      if (load) begin
        m_valid <= 1'b1; m_d <= res; m_zero <= (res == 8'h00);
        m_par <= ($countones(res) % 2) == 1; m_beats <= n;
      end else if (out_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Per-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    chk("in_ready", in_ready, !m_valid || out_ready);
    chk("out_valid", out_valid, m_valid);
    chk("out_d", out_d, m_d);
    chk("out_zero", out_zero, m_zero);
    chk("out_parity", out_parity, m_par);
    chk("out_beats", out_beats, sat(m_beats, 255));
    chk("in_ready2", in_ready2, !m_valid || out_ready);
    chk("out_valid2", out_valid2, m_valid);
    chk("out_d2", out_d2, m_d);
    chk("out_zero2", out_zero2, m_zero);
    chk("out_parity2", out_parity2, m_par);
    chk("out_beats2", out_beats2, sat(m_beats, 3));
  end

  task automatic beat(input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] op, input logic mode, input logic last);
    in_valid = v; in_a = a; in_b = b; in_op = op; in_mode = mode; in_last = last;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_d", out_d, 0);
    chk("rst_beats", out_beats, 0);
    chk("rst_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Elementwise AND.
    beat(1, 8'hF0, 8'h3C, 3'b000, 0, 0);
    chk("and_d", out_d, 8'h30);
    chk("and_zero", out_zero, 0);
    chk("and_par", out_parity, 0);
    chk("and_beats", out_beats, 1);
    chk("and_valid", out_valid, 1);

    // Reduce XOR over three beats.
    beat(1, 8'h01, 8'h00, 3'b010, 1, 0);
    chk("rx_b1_valid", out_valid, 0);
    beat(1, 8'h02, 8'hFF, 3'b000, 0, 0);
    chk("rx_b2_valid", out_valid, 0);
    beat(1, 8'h04, 8'h00, 3'b111, 0, 1);
    chk("rx_d", out_d, 8'h07);
    chk("rx_par", out_parity, 1);
    chk("rx_beats", out_beats, 3);

    // Backpressure with a pending beat.
    beat(1, 8'h0F, 8'hF0, 3'b001, 0, 0);
    chk("bp_d0", out_d, 8'hFF);
    out_ready = 1'b0;
    in_a = 8'hFF; in_b = 8'h0F; in_op = 3'b000; in_mode = 0; in_last = 0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready", in_ready, 0);
      chk("bp_hold_d", out_d, 8'hFF);
      chk("bp_hold_v", out_valid, 1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_next_d", out_d, 8'h0F);
    chk("bp_next_v", out_valid, 1);
    beat(0, 8'h00, 8'h00, 3'b000, 0, 0);
    chk("bp_drain", out_valid, 0);

    // PASS of zero and NOR of zeros.
    beat(1, 8'h77, 8'h00, 3'b111, 0, 0);
    chk("pass_zero", out_zero, 1);
    chk("pass_d", out_d, 8'h00);
    beat(1, 8'h00, 8'h00, 3'b101, 0, 0);
    chk("nor_d", out_d, 8'hFF);
    chk("nor_par", out_parity, 0);

    // All ops elementwise; checked by the model each cycle.
    for (int op = 0; op < 8; op++) beat(1, 8'hC5, 8'h3A, 3'(op), 0, 0);

    // Reset in the middle of a reduce packet.
    beat(1, 8'hF0, 8'h00, 3'b000, 1, 0);
    beat(1, 8'h3C, 8'h00, 3'b000, 1, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_v", out_valid, 0);
    chk("mid_rst_d", out_d, 0);
    chk("mid_rst_beats", out_beats, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    beat(1, 8'h5A, 8'h00, 3'b000, 1, 1);
    chk("fresh_d", out_d, 8'h5A);
    chk("fresh_beats", out_beats, 1);
    chk("fresh_beats2", out_beats2, 1);

    // Five-beat reduce OR with an idle gap; narrow counter saturates.
    beat(1, 8'h01, 8'h00, 3'b001, 1, 0);
    beat(1, 8'h02, 8'h00, 3'b001, 1, 0);
    beat(0, 8'hAA, 8'hAA, 3'b000, 0, 0);
    beat(1, 8'h04, 8'h00, 3'b001, 1, 0);
    beat(1, 8'h08, 8'h00, 3'b001, 1, 0);
    chk("sat_mid_valid", out_valid, 0);
    beat(1, 8'h10, 8'h00, 3'b001, 1, 1);
    chk("sat_d", out_d, 8'h1F);
    chk("sat_beats8", out_beats, 5);
    chk("sat_beats2", out_beats2, 3);
    chk("sat_par", out_parity, 1);

    // Mixed traffic under toggling backpressure; checked by the model.
    for (int i = 0; i < 24; i++) begin
      out_ready = (i % 3) != 1;
      beat(1, 8'(i * 37 + 5), 8'(i * 11), 3'(i), (i % 5) < 3, (i % 3) == 2);
    end
    out_ready = 1'b1;
    beat(0, 8'h00, 8'h00, 3'b000, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
